// File: rtl/fpga_connection_block.sv
// FPGA connection block: routes one channel (single, double, global lines)
// into the inputs of two neighbouring CLBs, lets each CLB output drive
// selected single/double tracks, passes carry between the CLBs and joins the
// two sides of every channel track.
module fpga_connection_block #(
    parameter int WS         = 7,
    parameter int WD         = 6,
    parameter int WG         = 3,
    parameter int CLBIN0     = 6,
    parameter int CLBIN1     = 6,
    parameter int CLBOUT0    = 1,
    parameter int CLBOUT1    = 1,
    parameter int CARRY      = 1,
    parameter int CLBOS      = 2,
    parameter int CLBOS_BIAS = 1,
    parameter int CLBOD      = 2,
    parameter int CLBOD_BIAS = 1,
    parameter int CLBX       = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    inout  wire  [WS-1:0]       single0,
    inout  wire  [WS-1:0]       single1,
    inout  wire  [WD-1:0]       double0,
    inout  wire  [WD-1:0]       double1,
    input  logic [WG-1:0]       global0,
    input  logic [CLBOUT0-1:0]  clb0_output,
    input  logic [CLBOUT1-1:0]  clb1_output,
    input  logic [CARRY-1:0]    clb0_cout,
    input  logic [CARRY-1:0]    clb1_cout,
    output logic [CLBIN0-1:0]   clb0_input,
    output logic [CLBIN1-1:0]   clb1_input,
    output logic [CARRY-1:0]    clb0_cin,
    output logic [CARRY-1:0]    clb1_cin,
    input  logic [CLBIN0*(WS+WD+WG+CLBX*CLBOUT1) + CLBOUT0*(CLBOS+CLBOD) +
                  CLBIN1*(WS+WD+WG+CLBX*CLBOUT0) + CLBOUT1*(CLBOS+CLBOD) - 1:0] c
);

    // Config field widths and block base offsets (LSB first, contiguous).
    localparam int FIN0  = WS + WD + WG + CLBX * CLBOUT1;
    localparam int FIN1  = WS + WD + WG + CLBX * CLBOUT0;
    localparam int FOUT  = CLBOS + CLBOD;
    localparam int OFF_A = 0;
    localparam int OFF_B = OFF_A + CLBIN0 * FIN0;
    localparam int OFF_C = OFF_B + CLBOUT0 * FOUT;
    localparam int OFF_D = OFF_C + CLBIN1 * FIN1;
    localparam int WDH   = WD / 2;

    // Non-negative modulo, used for the rotated output-to-track mapping.
    function automatic int wrap(input int v, input int m);
        int r;
        r = v % m;
        return (r < 0) ? (r + m) : r;
    endfunction

    logic              en_r;
    logic [CLBIN0-1:0] clb0_pin_s;
    logic [CLBIN1-1:0] clb1_pin_s;
    logic [WS-1:0]     single_en_s;
    logic [WS-1:0]     single_val_s;
    logic [WD-1:0]     double_en_s;
    logic [WD-1:0]     double_val_s;

    // Routing enable: held low in reset, set on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_r <= 1'b0;
        end else begin
            en_r <= 1'b1;
        end
    end

    // Input muxes: each pin is the OR of every source whose config bit is set.
    always_comb begin
        clb0_pin_s = '0;
        clb1_pin_s = '0;
        for (int i = 0; i < CLBIN0; i++) begin
            for (int j = 0; j < WS; j++)
                clb0_pin_s[i] = clb0_pin_s[i] | (c[OFF_A + i*FIN0 + j] & single0[j]);
            for (int j = 0; j < WD; j++)
                clb0_pin_s[i] = clb0_pin_s[i] | (c[OFF_A + i*FIN0 + WS + j] & double0[j]);
            for (int j = 0; j < WG; j++)
                clb0_pin_s[i] = clb0_pin_s[i] | (c[OFF_A + i*FIN0 + WS + WD + j] & global0[j]);
            for (int j = 0; j < CLBX*CLBOUT1; j++)
                clb0_pin_s[i] = clb0_pin_s[i] | (c[OFF_A + i*FIN0 + WS + WD + WG + j] & clb1_output[j]);
        end
        for (int i = 0; i < CLBIN1; i++) begin
            for (int j = 0; j < WS; j++)
                clb1_pin_s[i] = clb1_pin_s[i] | (c[OFF_C + i*FIN1 + j] & single0[j]);
            for (int j = 0; j < WD; j++)
                clb1_pin_s[i] = clb1_pin_s[i] | (c[OFF_C + i*FIN1 + WS + j] & double0[j]);
            for (int j = 0; j < WG; j++)
                clb1_pin_s[i] = clb1_pin_s[i] | (c[OFF_C + i*FIN1 + WS + WD + j] & global0[j]);
            for (int j = 0; j < CLBX*CLBOUT0; j++)
                clb1_pin_s[i] = clb1_pin_s[i] | (c[OFF_C + i*FIN1 + WS + WD + WG + j] & clb0_output[j]);
        end
    end

    // Output drivers: enables/values per track; doubles only reach the lower half.
    always_comb begin
        single_en_s  = '0;
        single_val_s = '0;
        double_en_s  = '0;
        double_val_s = '0;
        for (int i = 0; i < CLBOUT0; i++) begin
            for (int j = 0; j < CLBOS; j++) begin
                single_en_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] =
                    single_en_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] | (en_r & c[OFF_B + i*FOUT + j]);
                single_val_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] =
                    single_val_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] | (c[OFF_B + i*FOUT + j] & clb0_output[i]);
            end
            for (int j = 0; j < CLBOD; j++) begin
                double_en_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] =
                    double_en_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] | (en_r & c[OFF_B + i*FOUT + CLBOS + j]);
                double_val_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] =
                    double_val_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] | (c[OFF_B + i*FOUT + CLBOS + j] & clb0_output[i]);
            end
        end
        for (int i = 0; i < CLBOUT1; i++) begin
            for (int j = 0; j < CLBOS; j++) begin
                single_en_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] =
                    single_en_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] | (en_r & c[OFF_D + i*FOUT + j]);
                single_val_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] =
                    single_val_s[wrap(j - i*CLBOS - CLBOS_BIAS, WS)] | (c[OFF_D + i*FOUT + j] & clb1_output[i]);
            end
            for (int j = 0; j < CLBOD; j++) begin
                double_en_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] =
                    double_en_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] | (en_r & c[OFF_D + i*FOUT + CLBOS + j]);
                double_val_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] =
                    double_val_s[wrap(j - i*CLBOD - CLBOD_BIAS, WDH)] | (c[OFF_D + i*FOUT + CLBOS + j] & clb1_output[i]);
            end
        end
    end

    // Track sides: the block's own drive appears on both sides; otherwise
    // side 0 follows whatever the channel puts on side 1.
    for (genvar k = 0; k < WS; k++) begin : g_single
        assign single1[k] = single_en_s[k] ? single_val_s[k] : 1'bz;
        assign single0[k] = single_en_s[k] ? single_val_s[k] : single1[k];
    end

    for (genvar k = 0; k < WD; k++) begin : g_double
        assign double1[k] = double_en_s[k] ? double_val_s[k] : 1'bz;
        assign double0[k] = double_en_s[k] ? double_val_s[k] : double1[k];
    end

    assign clb0_input = en_r ? clb0_pin_s : '0;
    assign clb1_input = en_r ? clb1_pin_s : '0;

    // Carry crosses between the CLBs independent of reset and config.
    assign clb1_cin = clb0_cout;
    assign clb0_cin = clb1_cout;

endmodule

// File: tb/tb_fpga_connection_block.sv
// Scoreboard bench for fpga_connection_block at default parameters.
module tb_fpga_connection_block;

    localparam int WS = 7;
    localparam int WD = 6;
    localparam int WG = 3;
    localparam int NC = 212;
    localparam int C1_PIN5 = 106 + 5*17;

    localparam int K_CLB0 = 0;
    localparam int K_CLB1 = 1;
    localparam int K_S0HI = 2;
    localparam int K_S1HI = 3;
    localparam int K_D0HI = 4;
    localparam int K_D1HI = 5;
    localparam int K_CIN  = 6;
    localparam int K_S0   = 7;
    localparam int K_D0   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] c;
    logic [WG-1:0] global0;
    logic [0:0]    clb0_output, clb1_output, clb0_cout, clb1_cout;
    logic [5:0]    clb0_input, clb1_input;
    logic [0:0]    clb0_cin, clb1_cin;
    wire  [WS-1:0] single0_w, single1_w;
    wire  [WD-1:0] double0_w, double1_w;
    logic          s1_oe, d1_oe;
    logic [WS-1:0] s1_val;
    logic [WD-1:0] d1_val;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;
    exp_t sb_q[$];

    assign single1_w = s1_oe ? s1_val : 'z;
    assign double1_w = d1_oe ? d1_val : 'z;

    always #5 clk = ~clk;

    fpga_connection_block dut (
        .clk(clk), .rst_n(rst_n),
        .single0(single0_w), .single1(single1_w),
        .double0(double0_w), .double1(double1_w),
        .global0(global0),
        .clb0_output(clb0_output), .clb1_output(clb1_output),
        .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
        .clb0_input(clb0_input), .clb1_input(clb1_input),
        .clb0_cin(clb0_cin), .clb1_cin(clb1_cin),
        .c(c)
    );

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Bit k set when the line reads a solid 1 (undriven lines never qualify).
    function automatic logic [31:0] observe(input int kind);
        logic [31:0] m;
        m = 32'h0;
        case (kind)
            K_CLB0: m = {26'h0, clb0_input};
            K_CLB1: m = {26'h0, clb1_input};
            K_S0HI: for (int k = 0; k < WS; k++) m[k] = (single0_w[k] === 1'b1);
            K_S1HI: for (int k = 0; k < WS; k++) m[k] = (single1_w[k] === 1'b1);
            K_D0HI: for (int k = 0; k < WD; k++) m[k] = (double0_w[k] === 1'b1);
            K_D1HI: for (int k = 0; k < WD; k++) m[k] = (double1_w[k] === 1'b1);
            K_CIN:  m = {30'h0, clb1_cin, clb0_cin};
            K_S0:   m = {25'h0, single0_w};
            K_D0:   m = {26'h0, double0_w};
            default: m = 32'hDEAD_BEEF;
        endcase
        return m;
    endfunction

    task automatic expect_val(input int kind, input string tag, input logic [31:0] exp);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_value(e.tag, observe(e.kind), e.exp);
        end
    endtask

    task automatic expect_no_drive(input string tag);
        expect_val(K_S0HI, {tag, "_s0"}, 32'h0);
        expect_val(K_S1HI, {tag, "_s1"}, 32'h0);
        expect_val(K_D0HI, {tag, "_d0"}, 32'h0);
        expect_val(K_D1HI, {tag, "_d1"}, 32'h0);
    endtask

    // Reference source value for a field offset within one input pin's field.
    function automatic logic src_model(input int f, input logic opp);
        if (f < WS)                return s1_val[f];
        else if (f < WS + WD)      return d1_val[f - WS];
        else if (f < WS + WD + WG) return global0[f - WS - WD];
        else                       return opp;
    endfunction

    int   in_fields[6] = '{3, 8, 15, 16, 16, 0};
    int   out_bits[4]  = '{102, 103, 104, 105};
    int   out_dbl[4]   = '{0, 0, 1, 1};
    int   out_trk[4]   = '{6, 0, 2, 0};

    initial begin
        logic        opp;
        logic [31:0] m;
        rst_n = 1'b1; c = '1; global0 = 3'b101;
        clb0_output = 1'b1; clb1_output = 1'b1;
        clb0_cout = 1'b1; clb1_cout = 1'b0;
        s1_oe = 1'b0; d1_oe = 1'b0; s1_val = '0; d1_val = '0;
        #2 rst_n = 1'b0;

        // Reset: everything off even with all config bits set; carry still passes.
        @(negedge clk);
        expect_val(K_CLB0, "rst_clb0", 32'h0);
        expect_val(K_CLB1, "rst_clb1", 32'h0);
        expect_no_drive("rst");
        expect_val(K_CIN, "rst_carry", 32'h2);
        drain();

        // Release: still disabled until the first rising edge.
        @(negedge clk);
        c = '0; c[15] = 1'b1;
        rst_n = 1'b1;
        expect_val(K_CLB0, "pre_en", 32'h0);
        drain();
        @(posedge clk);
        expect_val(K_CLB0, "post_en", 32'h1);
        drain();

        // Input routing from channel-driven tracks.
        s1_val = 7'h55; d1_val = 6'h2A; s1_oe = 1'b1; d1_oe = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            opp = (k != 4);
            clb0_output = opp; clb1_output = opp;
            c = '0; c[in_fields[k]] = 1'b1;
            expect_val(K_CLB0, $sformatf("in0_f%0d", in_fields[k]), {31'h0, src_model(in_fields[k], opp)});
            expect_val(K_CLB1, $sformatf("in0_c1_f%0d", in_fields[k]), 32'h0);
            drain();
            @(negedge clk);
            c = '0; c[C1_PIN5 + in_fields[k]] = 1'b1;
            expect_val(K_CLB1, $sformatf("in5_f%0d", in_fields[k]), {26'h0, src_model(in_fields[k], opp), 5'h0});
            expect_val(K_CLB0, $sformatf("in5_c0_f%0d", in_fields[k]), 32'h0);
            drain();
        end
        @(negedge clk);
        c = '0; c[3] = 1'b1; c[4] = 1'b1;
        expect_val(K_CLB0, "in_or", 32'h1);
        drain();

        // Output routing: each CLB output onto its rotated track.
        s1_oe = 1'b0; d1_oe = 1'b0;
        for (int clb = 0; clb < 2; clb++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                clb0_output = (clb == 0); clb1_output = (clb == 1);
                c = '0; c[out_bits[k] + clb*106] = 1'b1;
                m = 32'h1 << out_trk[k];
                expect_val(K_S0HI, $sformatf("out%0d_b%0d_s0", clb, k), out_dbl[k] ? 32'h0 : m);
                expect_val(K_S1HI, $sformatf("out%0d_b%0d_s1", clb, k), out_dbl[k] ? 32'h0 : m);
                expect_val(K_D0HI, $sformatf("out%0d_b%0d_d0", clb, k), out_dbl[k] ? m : 32'h0);
                expect_val(K_D1HI, $sformatf("out%0d_b%0d_d1", clb, k), out_dbl[k] ? m : 32'h0);
                drain();
            end
        end
        @(negedge clk);
        clb0_output = 1'b0; c = '0; c[102] = 1'b1;
        expect_val(K_S0HI, "out_low", 32'h0);
        drain();

        // Shorting: random values driven on side 1 only appear on side 0.
        c = '0; s1_oe = 1'b1; d1_oe = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s1_val = WS'($urandom); d1_val = WD'($urandom);
            expect_val(K_S0, $sformatf("short_s_%0d", k), {25'h0, s1_val});
            expect_val(K_D0, $sformatf("short_d_%0d", k), {26'h0, d1_val});
            drain();
        end

        // Carry swapped while routing is enabled.
        @(negedge clk);
        clb0_cout = 1'b0; clb1_cout = 1'b1;
        expect_val(K_CIN, "carry_en", 32'h1);
        drain();

        // Empty config: nothing selected, nothing driven.
        @(negedge clk);
        s1_oe = 1'b0; d1_oe = 1'b0; c = '0;
        global0 = 3'b111; clb0_output = 1'b1; clb1_output = 1'b1;
        expect_val(K_CLB0, "empty_clb0", 32'h0);
        expect_val(K_CLB1, "empty_clb1", 32'h0);
        expect_no_drive("empty");
        drain();

        // Asynchronous reset mid-run blanks routing immediately.
        @(negedge clk);
        c[15] = 1'b1; c[102] = 1'b1;
        expect_val(K_CLB0, "pre_rst2", 32'h1);
        expect_val(K_S0HI, "pre_rst2_s0", 32'h40);
        drain();
        rst_n = 1'b0;
        expect_val(K_CLB0, "rst2_clb0", 32'h0);
        expect_no_drive("rst2");
        expect_val(K_CIN, "rst2_carry", 32'h1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fpga_connection_block.md
Name: fpga_connection_block

Overview:
- Configurable FPGA connection block between two CLBs (CLB0, CLB1) and one routing channel.
- The channel has single tracks, double tracks and global lines.
- Per-input config bits select which track, global line or opposite-CLB output feeds each CLB input pin.
- Per-output config bits select which single or double track each CLB output drives.
- The block also passes carry between the two CLBs and shorts the two sides of every channel track.

Parameters:
- WS, 7, number of single tracks.
- WD, 6, number of double tracks (even).
- WG, 3, number of global lines.
- CLBIN0 / CLBIN1, 6 / 6, input pins of CLB0 / CLB1.
- CLBOUT0 / CLBOUT1, 1 / 1, output pins of CLB0 / CLB1.
- CARRY, 1, carry width.
- CLBOS, 2, single-track choices per CLB output.
- CLBOS_BIAS, 1, single-track rotation offset.
- CLBOD, 2, double-track choices per CLB output.
- CLBOD_BIAS, 1, double-track rotation offset.
- CLBX, 1, when 1 each CLB input may also select the opposite CLB's outputs.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- single0  inout  WS  single tracks, side 0.
- single1  inout  WS  single tracks, side 1.
- double0  inout  WD  double tracks, side 0.
- double1  inout  WD  double tracks, side 1.
- global0  input  WG  global lines.
- clb0_output  input  CLBOUT0  CLB0 outputs.
- clb1_output  input  CLBOUT1  CLB1 outputs.
- clb0_cout  input  CARRY  CLB0 carry out.
- clb1_cout  input  CARRY  CLB1 carry out.
- clb0_input  output  CLBIN0  CLB0 input pins.
- clb1_input  output  CLBIN1  CLB1 input pins.
- clb0_cin  output  CARRY  CLB0 carry in.
- clb1_cin  output  CARRY  CLB1 carry in.
- c  input  NC  configuration bits.
  - NC = CLBIN0*(WS+WD+WG+CLBX*CLBOUT1) + CLBOUT0*(CLBOS+CLBOD) + CLBIN1*(WS+WD+WG+CLBX*CLBOUT0) + CLBOUT1*(CLBOS+CLBOD).
  - NC = 212 at the defaults.

Behaviour:
- Reset and enable:
  - One flop, en, is cleared asynchronously while rst_n=0 and set to 1 on the first posedge clk after release.
  - While en=0: every clb*_input is 0 and no CLB output drives any track (all track drivers Z).
  - All routing below applies while en=1 and is purely combinational from c and the data inputs (zero latency).
- Track shorting, always active regardless of en: single0[k]≡single1[k] and double0[k]≡double1[k]. Implement as bidirectional connections (tran/alias), so a value driven on either side appears on both.
- Carry, always active: clb1_cin = clb0_cout; clb0_cin = clb1_cout.
- Config layout, LSB first, fields contiguous:
  - Block A: for each CLB0 input i = 0..CLBIN0-1, in order: WS single-select bits, WD double-select bits, WG global-select bits, then (if CLBX) CLBOUT1 bits selecting clb1_output.
  - Block B: for each CLB0 output i: CLBOS bits, then CLBOD bits.
  - Block C: CLB1 inputs, same structure as A, with the CLBX field selecting clb0_output (CLBOUT0 bits).
  - Block D: CLB1 outputs, same as B.
- Input muxes: bit j of a field set connects that source (single0[j], double0[j], global0[j], or the opposite CLB output[j]) to the pin.
  - Pin value = OR of all selected sources; no bit set gives 0.
  - Configurations with more than one bit set per pin are unsupported; the OR result is still defined.
- Output drivers: CLB output i of either CLB, with CLBOS bit j set, drives single track (j − i*CLBOS − CLBOS_BIAS) mod WS.
  - With CLBOD bit j set it drives double track (j − i*CLBOD − CLBOD_BIAS) mod (WD/2), i.e. lower half of the doubles only.
  - An undriven track is Z.
  - Two drivers enabled on one track is illegal configuration (contention, result X).
- Changing c takes effect combinationally; no glitch-free requirement.

Test Plan:
- Reset: rst_n=0, c all-ones → clb0_input=0, clb1_input=0, no track driven by the block. Release rst_n, one posedge clk → routing active.
- Input routing: en=1, drive single0=7'h55, double0=6'h2A, global0=3'b101. Set c[3] (CLB0 input 0, single 3) → clb0_input[0]=0. Then only c[7+1] → clb0_input[0]=double0[1]=1. Then only c[13+2] → 1. Then only c[16] with clb1_output=1 → 1. Repeat for CLB1 input 5 at its base offset.
- Output routing, defaults: tracks released; clb0_output=1.
  - c[102] → single0[6]=single1[6]=1, all other singles Z.
  - Only c[103] → single0[0]=1.
  - Only c[104] → double0[2]=1.
  - Only c[105] → double0[0]=1.
  - Same checks for clb1_output using bits 208..211.
- Shorting/carry: random drive of single1/double1 only from side 1 → side 0 equals side 1 every cycle. clb0_cout=1, clb1_cout=0 → clb1_cin=1, clb0_cin=0, including while rst_n=0.
- Empty config: c=0 → all clb inputs 0, no track driven, tracks still shorted side-to-side.
